// File: rtl/bcd_time_entry_pkg.sv
// Shared definitions for the digit-serial time-set front end:
// state encodings, digit limits, cursor one-hot constants and helpers.
package bcd_time_entry_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_H1   = 3'd1,
        ST_H0   = 3'd2,
        ST_M1   = 3'd3,
        ST_M0   = 3'd4,
        ST_S1   = 3'd5,
        ST_S0   = 3'd6,
        ST_CONV = 3'd7
    } state_t;

    localparam logic [3:0] HOUR_TENS_MAX       = 4'd2;
    localparam logic [3:0] HOUR_UNITS_MAX_AT_2 = 4'd3;
    localparam logic [3:0] TENS_MAX_MS         = 4'd5;
    localparam logic [3:0] BCD_MAX             = 4'd9;

    localparam logic [5:0] CUR_H1   = 6'b100000;
    localparam logic [5:0] CUR_H0   = 6'b010000;
    localparam logic [5:0] CUR_M1   = 6'b001000;
    localparam logic [5:0] CUR_M0   = 6'b000100;
    localparam logic [5:0] CUR_S1   = 6'b000010;
    localparam logic [5:0] CUR_S0   = 6'b000001;
    localparam logic [5:0] CUR_NONE = 6'b000000;

    // Cursor position shown while waiting in a given state (none outside entry).
    function automatic logic [5:0] cursor_of(input state_t st);
        logic [5:0] cur;
        case (st)
            ST_H1:   cur = CUR_H1;
            ST_H0:   cur = CUR_H0;
            ST_M1:   cur = CUR_M1;
            ST_M0:   cur = CUR_M0;
            ST_S1:   cur = CUR_S1;
            ST_S0:   cur = CUR_S0;
            default: cur = CUR_NONE;
        endcase
        return cur;
    endfunction

    // Entry state that follows a successful digit; S0 hands over to conversion.
    function automatic state_t next_entry(input state_t st);
        state_t nxt;
        case (st)
            ST_H1:   nxt = ST_H0;
            ST_H0:   nxt = ST_M1;
            ST_M1:   nxt = ST_M0;
            ST_M0:   nxt = ST_S1;
            ST_S1:   nxt = ST_S0;
            ST_S0:   nxt = ST_CONV;
            default: nxt = ST_IDLE;
        endcase
        return nxt;
    endfunction

    // Range check for one digit; hour units depend on the hour tens already entered.
    function automatic logic digit_ok(input state_t st, input logic [3:0] d,
                                      input logic [3:0] hour_tens);
        logic ok;
        ok = 1'b0;
        if (d > BCD_MAX) begin
            ok = 1'b0;
        end else begin
            case (st)
                ST_H1:   ok = (d <= HOUR_TENS_MAX);
                ST_H0:   ok = (hour_tens == HOUR_TENS_MAX) ? (d <= HOUR_UNITS_MAX_AT_2) : 1'b1;
                ST_M1:   ok = (d <= TENS_MAX_MS);
                ST_M0:   ok = 1'b1;
                ST_S1:   ok = (d <= TENS_MAX_MS);
                ST_S0:   ok = 1'b1;
                default: ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_time_entry_bcd2bin_2digit.sv
// Two-digit BCD to binary: tens*10 + units as shift-and-add, 7-bit result.
module bcd2bin_2digit (
    input  logic [3:0] i_tens,
    input  logic [3:0] i_units,
    output logic [6:0] o_bin
);

    logic [6:0] w_tens;
    logic [6:0] w_units;

    assign w_tens  = {3'b000, i_tens};
    assign w_units = {3'b000, i_units};
    assign o_bin   = (w_tens << 3) + (w_tens << 1) + w_units;

endmodule

// File: rtl/bcd_time_entry.sv
// Digit-serial HH MM SS entry: range-checks each keypad digit, echoes the
// partial entry, converts to binary and strobes one load into the clock.
module bcd_time_entry
    import bcd_time_entry_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int TO_W           = 26
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_cancel,
    input  logic       i_digit_valid,
    input  logic [3:0] i_digit,
    output logic       o_busy,
    output logic [5:0] o_cursor,
    output logic [3:0] o_bcd5,
    output logic [3:0] o_bcd4,
    output logic [3:0] o_bcd3,
    output logic [3:0] o_bcd2,
    output logic [3:0] o_bcd1,
    output logic [3:0] o_bcd0,
    output logic [4:0] o_hour,
    output logic [5:0] o_min,
    output logic [5:0] o_sec,
    output logic       o_set_valid,
    output logic       o_err,
    output logic       o_timeout
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t            r_state;
    logic [5:0]        r_cursor;
    logic              r_busy;
    logic [23:0]       r_bcd;      // [23:20]=hour tens ... [3:0]=sec units
    logic [TO_W-1:0]   r_to_cnt;
    logic [4:0]        r_hour;
    logic [5:0]        r_min;
    logic [5:0]        r_sec;
    logic              r_set_valid;
    logic              r_err;
    logic              r_timeout;

    logic [23:0]       w_bcd_wr;
    logic              w_digit_ok;
    logic [6:0]        w_hour_bin;
    logic [6:0]        w_min_bin;
    logic [6:0]        w_sec_bin;

    bcd2bin_2digit u_hour (.i_tens(r_bcd[23:20]), .i_units(r_bcd[19:16]), .o_bin(w_hour_bin));
    bcd2bin_2digit u_min  (.i_tens(r_bcd[15:12]), .i_units(r_bcd[11:8]),  .o_bin(w_min_bin));
    bcd2bin_2digit u_sec  (.i_tens(r_bcd[7:4]),   .i_units(r_bcd[3:0]),   .o_bin(w_sec_bin));

    assign w_digit_ok = digit_ok(r_state, i_digit, r_bcd[23:20]);

    // Digit register image with the incoming digit placed at the current cursor slot.
    always_comb begin
        w_bcd_wr = r_bcd;
        case (r_state)
            ST_H1:   w_bcd_wr[23:20] = i_digit;
            ST_H0:   w_bcd_wr[19:16] = i_digit;
            ST_M1:   w_bcd_wr[15:12] = i_digit;
            ST_M0:   w_bcd_wr[11:8]  = i_digit;
            ST_S1:   w_bcd_wr[7:4]   = i_digit;
            ST_S0:   w_bcd_wr[3:0]   = i_digit;
            default: w_bcd_wr        = r_bcd;
        endcase
    end

    // Entry FSM with digit capture, idle timeout and registered time/strobe outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_cursor    <= CUR_NONE;
            r_busy      <= 1'b0;
            r_bcd       <= 24'd0;
            r_to_cnt    <= {TO_W{1'b0}};
            r_hour      <= 5'd0;
            r_min       <= 6'd0;
            r_sec       <= 6'd0;
            r_set_valid <= 1'b0;
            r_err       <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_set_valid <= 1'b0;
            r_err       <= 1'b0;
            r_timeout   <= 1'b0;
            if (i_cancel) begin
                r_state  <= ST_IDLE;
                r_cursor <= CUR_NONE;
                r_busy   <= 1'b0;
                r_bcd    <= 24'd0;
                r_to_cnt <= {TO_W{1'b0}};
            end else if (i_start) begin
                r_state  <= ST_H1;
                r_cursor <= CUR_H1;
                r_busy   <= 1'b1;
                r_bcd    <= 24'd0;
                r_to_cnt <= {TO_W{1'b0}};
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_to_cnt <= {TO_W{1'b0}};
                    end
                    ST_CONV: begin
                        // Upper bits are zero for any accepted digit pair.
                        r_hour      <= 5'(w_hour_bin);
                        r_min       <= 6'(w_min_bin);
                        r_sec       <= 6'(w_sec_bin);
                        r_set_valid <= 1'b1;
                        r_state     <= ST_IDLE;
                        r_cursor    <= CUR_NONE;
                        r_busy      <= 1'b0;
                        r_to_cnt    <= {TO_W{1'b0}};
                    end
                    default: begin
                        if (r_to_cnt == TO_LAST) begin
                            r_state   <= ST_IDLE;
                            r_cursor  <= CUR_NONE;
                            r_busy    <= 1'b0;
                            r_bcd     <= 24'd0;
                            r_to_cnt  <= {TO_W{1'b0}};
                            r_timeout <= 1'b1;
                        end else if (i_digit_valid) begin
                            if (w_digit_ok) begin
                                r_bcd    <= w_bcd_wr;
                                r_state  <= next_entry(r_state);
                                r_cursor <= cursor_of(next_entry(r_state));
                                r_to_cnt <= {TO_W{1'b0}};
                            end else begin
                                // Rejected digit leaves state, digits and counter alone.
                                r_err <= 1'b1;
                            end
                        end else begin
                            r_to_cnt <= r_to_cnt + {{(TO_W-1){1'b0}}, 1'b1};
                        end
                    end
                endcase
            end
        end
    end

    assign o_busy      = r_busy;
    assign o_cursor    = r_cursor;
    assign o_bcd5      = r_bcd[23:20];
    assign o_bcd4      = r_bcd[19:16];
    assign o_bcd3      = r_bcd[15:12];
    assign o_bcd2      = r_bcd[11:8];
    assign o_bcd1      = r_bcd[7:4];
    assign o_bcd0      = r_bcd[3:0];
    assign o_hour      = r_hour;
    assign o_min       = r_min;
    assign o_sec       = r_sec;
    assign o_set_valid = r_set_valid;
    assign o_err       = r_err;
    assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_bcd_time_entry.sv
// Directed bench for bcd_time_entry: per-cycle vector table plus
// hand-written sequences for cancel, timeout, restart and reset.
module tb_bcd_time_entry;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_start = 1'b0;
    logic       i_cancel = 1'b0;
    logic       i_digit_valid = 1'b0;
    logic [3:0] i_digit = 4'd0;
    logic       o_busy;
    logic [5:0] o_cursor;
    logic [3:0] o_bcd5, o_bcd4, o_bcd3, o_bcd2, o_bcd1, o_bcd0;
    logic [4:0] o_hour;
    logic [5:0] o_min;
    logic [5:0] o_sec;
    logic       o_set_valid;
    logic       o_err;
    logic       o_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    bcd_time_entry #(.TIMEOUT_CYCLES(8), .TO_W(26)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_cancel(i_cancel),
        .i_digit_valid(i_digit_valid), .i_digit(i_digit),
        .o_busy(o_busy), .o_cursor(o_cursor),
        .o_bcd5(o_bcd5), .o_bcd4(o_bcd4), .o_bcd3(o_bcd3),
        .o_bcd2(o_bcd2), .o_bcd1(o_bcd1), .o_bcd0(o_bcd0),
        .o_hour(o_hour), .o_min(o_min), .o_sec(o_sec),
        .o_set_valid(o_set_valid), .o_err(o_err), .o_timeout(o_timeout)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        st, ca, dv;
        logic [3:0]  dg;
        logic        busy;
        logic [5:0]  cur;
        logic        err, sv;
        logic [23:0] bcd;
        logic [4:0]  hr;
        logic [5:0]  mn, sc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic st, ca, dv, input logic [3:0] dg,
                               input logic busy, input logic [5:0] cur,
                               input logic err, sv, input logic [23:0] bcd,
                               input logic [4:0] hr, input logic [5:0] mn, sc);
        vec_t r;
        r.st = st; r.ca = ca; r.dv = dv; r.dg = dg;
        r.busy = busy; r.cur = cur; r.err = err; r.sv = sv;
        r.bcd = bcd; r.hr = hr; r.mn = mn; r.sc = sc;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, sample 1 time unit later.
    task automatic step(input logic st, ca, dv, input logic [3:0] dg);
        i_start = st; i_cancel = ca; i_digit_valid = dv; i_digit = dg;
        @(posedge i_clk);
        #1;
        i_start = 1'b0; i_cancel = 1'b0; i_digit_valid = 1'b0; i_digit = 4'd0;
    endtask

    function automatic logic [23:0] bcd_all();
        return {o_bcd5, o_bcd4, o_bcd3, o_bcd2, o_bcd1, o_bcd0};
    endfunction

    function automatic logic [16:0] tim();
        return {o_hour, o_min, o_sec};
    endfunction

    task automatic enter6(input logic [23:0] d);
        logic [23:0] dd;
        dd = d;
        step(1'b1, 1'b0, 1'b0, 4'd0);
        for (int k = 5; k >= 0; k--) step(1'b0, 1'b0, 1'b1, dd[4*k +: 4]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Scenario 1: 23:59:59
        vecs.push_back(v(1,0,0,4'd0, 1,6'b100000,0,0,24'h000000, 5'd0,6'd0,6'd0));
        vecs.push_back(v(0,0,1,4'd2, 1,6'b010000,0,0,24'h200000, 5'd0,6'd0,6'd0));
        vecs.push_back(v(0,0,1,4'd3, 1,6'b001000,0,0,24'h230000, 5'd0,6'd0,6'd0));
        vecs.push_back(v(0,0,1,4'd5, 1,6'b000100,0,0,24'h235000, 5'd0,6'd0,6'd0));
        vecs.push_back(v(0,0,1,4'd9, 1,6'b000010,0,0,24'h235900, 5'd0,6'd0,6'd0));
        vecs.push_back(v(0,0,1,4'd5, 1,6'b000001,0,0,24'h235950, 5'd0,6'd0,6'd0));
        vecs.push_back(v(0,0,1,4'd9, 1,6'b000000,0,0,24'h235959, 5'd0,6'd0,6'd0));
        vecs.push_back(v(0,0,0,4'd0, 0,6'b000000,0,1,24'h235959, 5'd23,6'd59,6'd59));
        vecs.push_back(v(0,0,0,4'd0, 0,6'b000000,0,0,24'h235959, 5'd23,6'd59,6'd59));
        // Scenario 2: rejects at H0 (4 after 2), M1 (7), M0 (0xA), S1 (6) -> 20:10:00
        vecs.push_back(v(1,0,0,4'd0, 1,6'b100000,0,0,24'h000000, 5'd23,6'd59,6'd59));
        vecs.push_back(v(0,0,1,4'd2, 1,6'b010000,0,0,24'h200000, 5'd23,6'd59,6'd59));
        vecs.push_back(v(0,0,1,4'd4, 1,6'b010000,1,0,24'h200000, 5'd23,6'd59,6'd59));
        vecs.push_back(v(0,0,1,4'd0, 1,6'b001000,0,0,24'h200000, 5'd23,6'd59,6'd59));
        vecs.push_back(v(0,0,1,4'd7, 1,6'b001000,1,0,24'h200000, 5'd23,6'd59,6'd59));
        vecs.push_back(v(0,0,1,4'd1, 1,6'b000100,0,0,24'h201000, 5'd23,6'd59,6'd59));
        vecs.push_back(v(0,0,1,4'hA, 1,6'b000100,1,0,24'h201000, 5'd23,6'd59,6'd59));
        vecs.push_back(v(0,0,1,4'd0, 1,6'b000010,0,0,24'h201000, 5'd23,6'd59,6'd59));
        vecs.push_back(v(0,0,1,4'd6, 1,6'b000010,1,0,24'h201000, 5'd23,6'd59,6'd59));
        vecs.push_back(v(0,0,1,4'd0, 1,6'b000001,0,0,24'h201000, 5'd23,6'd59,6'd59));
        vecs.push_back(v(0,0,1,4'd0, 1,6'b000000,0,0,24'h201000, 5'd23,6'd59,6'd59));
        vecs.push_back(v(0,0,0,4'd0, 0,6'b000000,0,1,24'h201000, 5'd20,6'd10,6'd0));
        // Scenario 5: 0,9,3 then restart, then 00:00:00
        vecs.push_back(v(1,0,0,4'd0, 1,6'b100000,0,0,24'h000000, 5'd20,6'd10,6'd0));
        vecs.push_back(v(0,0,1,4'd0, 1,6'b010000,0,0,24'h000000, 5'd20,6'd10,6'd0));
        vecs.push_back(v(0,0,1,4'd9, 1,6'b001000,0,0,24'h090000, 5'd20,6'd10,6'd0));
        vecs.push_back(v(0,0,1,4'd3, 1,6'b000100,0,0,24'h093000, 5'd20,6'd10,6'd0));
        vecs.push_back(v(1,0,0,4'd0, 1,6'b100000,0,0,24'h000000, 5'd20,6'd10,6'd0));
        vecs.push_back(v(0,0,1,4'd0, 1,6'b010000,0,0,24'h000000, 5'd20,6'd10,6'd0));
        vecs.push_back(v(0,0,1,4'd0, 1,6'b001000,0,0,24'h000000, 5'd20,6'd10,6'd0));
        vecs.push_back(v(0,0,1,4'd0, 1,6'b000100,0,0,24'h000000, 5'd20,6'd10,6'd0));
        vecs.push_back(v(0,0,1,4'd0, 1,6'b000010,0,0,24'h000000, 5'd20,6'd10,6'd0));
        vecs.push_back(v(0,0,1,4'd0, 1,6'b000001,0,0,24'h000000, 5'd20,6'd10,6'd0));
        vecs.push_back(v(0,0,1,4'd0, 1,6'b000000,0,0,24'h000000, 5'd20,6'd10,6'd0));
        vecs.push_back(v(0,0,0,4'd0, 0,6'b000000,0,1,24'h000000, 5'd0,6'd0,6'd0));
        // Scenario 6a: digit in IDLE is ignored
        vecs.push_back(v(0,0,1,4'd4, 0,6'b000000,0,0,24'h000000, 5'd0,6'd0,6'd0));

        // Reset
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        chk("rst.busy", 32'(o_busy), 32'd0);
        chk("rst.cursor", 32'(o_cursor), 32'd0);
        chk("rst.bcd", 32'(bcd_all()), 32'd0);
        chk("rst.time", 32'(tim()), 32'd0);
        chk("rst.strobes", 32'({o_set_valid, o_err, o_timeout}), 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].st, vecs[i].ca, vecs[i].dv, vecs[i].dg);
            chk($sformatf("v%0d.busy", i), 32'(o_busy), 32'(vecs[i].busy));
            chk($sformatf("v%0d.cursor", i), 32'(o_cursor), 32'(vecs[i].cur));
            chk($sformatf("v%0d.err", i), 32'(o_err), 32'(vecs[i].err));
            chk($sformatf("v%0d.set_valid", i), 32'(o_set_valid), 32'(vecs[i].sv));
            chk($sformatf("v%0d.timeout", i), 32'(o_timeout), 32'd0);
            chk($sformatf("v%0d.bcd", i), 32'(bcd_all()), 32'(vecs[i].bcd));
            chk($sformatf("v%0d.time", i), 32'(tim()), 32'({vecs[i].hr, vecs[i].mn, vecs[i].sc}));
        end

        // Load 12:34:56, then cancel a partial entry
        enter6(24'h123456);
        step(1'b0, 1'b0, 1'b0, 4'd0);
        chk("load1234.time", 32'(tim()), 32'({5'd12, 6'd34, 6'd56}));
        step(1'b1, 1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b0, 1'b1, 4'd1);
        step(1'b0, 1'b0, 1'b1, 4'd2);
        step(1'b0, 1'b0, 1'b1, 4'd3);
        chk("precancel.bcd", 32'(bcd_all()), 32'h123000);
        step(1'b0, 1'b1, 1'b0, 4'd0);
        chk("cancel.busy", 32'(o_busy), 32'd0);
        chk("cancel.cursor", 32'(o_cursor), 32'd0);
        chk("cancel.bcd", 32'(bcd_all()), 32'd0);
        chk("cancel.strobes", 32'({o_set_valid, o_err}), 32'd0);
        step(1'b0, 1'b0, 1'b0, 4'd0);
        chk("cancel.sv_next", 32'(o_set_valid), 32'd0);
        chk("cancel.time", 32'(tim()), 32'({5'd12, 6'd34, 6'd56}));

        // Start during CONV drops that conversion
        enter6(24'h111111);
        chk("conv.busy", 32'(o_busy), 32'd1);
        step(1'b1, 1'b0, 1'b0, 4'd0);
        chk("convstart.sv", 32'(o_set_valid), 32'd0);
        chk("convstart.cursor", 32'(o_cursor), 32'b100000);
        chk("convstart.bcd", 32'(bcd_all()), 32'd0);
        step(1'b0, 1'b0, 1'b0, 4'd0);
        chk("convstart.sv_next", 32'(o_set_valid), 32'd0);
        chk("convstart.time", 32'(tim()), 32'({5'd12, 6'd34, 6'd56}));

        // Cancel and start on the same edge: cancel wins
        step(1'b1, 1'b1, 1'b0, 4'd0);
        chk("cancel_start.busy", 32'(o_busy), 32'd0);
        chk("cancel_start.cursor", 32'(o_cursor), 32'd0);

        // Timeout: 8 idle cycles after the last accepted digit
        step(1'b1, 1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b0, 1'b1, 4'd1);
        chk("to.bcd5", 32'(o_bcd5), 32'd1);
        for (int k = 0; k < 7; k++) step(1'b0, 1'b0, 1'b0, 4'd0);
        chk("to.before.busy", 32'(o_busy), 32'd1);
        chk("to.before.timeout", 32'(o_timeout), 32'd0);
        step(1'b0, 1'b0, 1'b0, 4'd0);
        chk("to.timeout", 32'(o_timeout), 32'd1);
        chk("to.busy", 32'(o_busy), 32'd0);
        chk("to.cursor", 32'(o_cursor), 32'd0);
        chk("to.bcd5", 32'(o_bcd5), 32'd0);
        chk("to.time", 32'(tim()), 32'({5'd12, 6'd34, 6'd56}));
        step(1'b0, 1'b0, 1'b0, 4'd0);
        chk("to.pulse_end", 32'(o_timeout), 32'd0);

        // Reset mid-entry clears everything, including the loaded time
        step(1'b1, 1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b0, 1'b1, 4'd2);
        i_rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 4'd0);
        i_rst = 1'b0;
        chk("midrst.busy", 32'(o_busy), 32'd0);
        chk("midrst.cursor", 32'(o_cursor), 32'd0);
        chk("midrst.bcd", 32'(bcd_all()), 32'd0);
        chk("midrst.time", 32'(tim()), 32'd0);
        chk("midrst.strobes", 32'({o_set_valid, o_err, o_timeout}), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
